spi_mem_target: RTL



---
 rtl/spi_mem_pkg.sv | 25 ++
 rtl/spi_mem_target_sync.sv | 39 +++
 rtl/spi_mem_target.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared opcodes and FSM state encoding for the SPI memory target.
// Imported by the top and the input synchronizer.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Bit-counter terminal values for the byte and 24-bit address phases
  localparam logic [4:0] BYTE_LAST = 5'd7;
  localparam logic [4:0] ADDR_LAST = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_IGNORE
  } state_e;

  function automatic logic cmd_supported(input logic [7:0] op);
    return (op == CMD_READ) || (op == CMD_WRITE);
  endfunction

endpackage

// File: rtl/spi_mem_target_sync.sv
// Multi-stage synchronizer for the SPI pins with sck rise/fall and cs_n fall strobes.
// The flops track the pins regardless of rst_n so a held-low cs_n never looks like a new edge.
module spi_in_sync
  import spi_mem_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_n_o,
  output logic cs_fall_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  always_ff @(posedge clk) begin
    sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
  end

  assign sck_rise_o = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
  assign cs_n_o     = cs_sync_q[SYNC_STAGES-1];
  assign cs_fall_o  = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
  assign mosi_o     = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_target.sv
// SPI mode-0 memory responder (READ 0x03 / WRITE 0x02, 24-bit address, auto-increment)
// backed by a byte array that a host port can preload and inspect while SPI is idle.
module spi_mem_target
  import spi_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sck,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 busy,
  output logic                 cmd_err,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic sck_rise, sck_fall, cs_n_s, cs_fall, mosi_s;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .sck_i     (spi_sck),
    .cs_n_i    (spi_cs_n),
    .mosi_i    (spi_mosi),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .cs_n_o    (cs_n_s),
    .cs_fall_o (cs_fall),
    .mosi_o    (mosi_s)
  );

  logic [7:0]           mem_q [DEPTH];

  state_e               state_q, state_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [6:0]           rx_q, rx_d;
  logic [7:0]           tx_q, tx_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 write_op_q, write_op_d;
  logic                 miso_q, miso_d;
  logic                 oe_q, oe_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 busy_q;
  logic [7:0]           host_rdata_q;

  logic [7:0]           rx_byte;
  logic [ADDR_BITS-1:0] addr_shift;
  logic [ADDR_BITS-1:0] addr_inc;
  logic                 spi_we;
  logic [7:0]           spi_wdata;

  assign rx_byte    = {rx_q, mosi_s};
  assign addr_shift = {addr_q[ADDR_BITS-2:0], mosi_s};
  assign addr_inc   = addr_q + ADDR_BITS'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Deasserted chip select always wins, so sck edges with cs_n high are ignored
  always_comb begin
    state_d = state_q;
    if (cs_n_s) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (sck_rise && bit_cnt_q == BYTE_LAST)
            state_d = cmd_supported(rx_byte) ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR: begin
          if (sck_rise && bit_cnt_q == ADDR_LAST)
            state_d = write_op_q ? ST_WR : ST_RD;
        end
        ST_RD, ST_WR, ST_IGNORE: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    write_op_d = write_op_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    cmd_err_d  = 1'b0;
    spi_we     = 1'b0;
    spi_wdata  = rx_byte;
    if (cs_n_s) begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
          if (cs_fall) rx_d = '0;
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_d = rx_byte[6:0];
            if (bit_cnt_q == BYTE_LAST) begin
              bit_cnt_d  = '0;
              write_op_d = (rx_byte == CMD_WRITE);
              cmd_err_d  = ~cmd_supported(rx_byte);
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            addr_d = addr_shift;
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_d = '0;
              if (!write_op_q) tx_d = mem_q[addr_shift];
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_RD: begin
          // Each fall presents tx[7] and pre-shifts; the byte boundary reloads on the 8th rise
          if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
            oe_d   = 1'b1;
          end else if (sck_rise) begin
            if (bit_cnt_q == BYTE_LAST) begin
              bit_cnt_d = '0;
              addr_d    = addr_inc;
              tx_d      = mem_q[addr_inc];
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_WR: begin
          if (sck_rise) begin
            rx_d = rx_byte[6:0];
            if (bit_cnt_q == BYTE_LAST) begin
              bit_cnt_d = '0;
              spi_we    = 1'b1;
              addr_d    = addr_inc;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_IGNORE: bit_cnt_d = bit_cnt_q;
        default:   bit_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      write_op_q   <= 1'b0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      cmd_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      host_rdata_q <= 8'h00;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      write_op_q   <= write_op_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      cmd_err_q    <= cmd_err_d;
      busy_q       <= ~cs_n_s;
      host_rdata_q <= mem_q[host_addr];
    end
  end

  // SPI has priority; host writes only land while the bus is idle
  always_ff @(posedge clk) begin
    if (spi_we && rst_n)
      mem_q[addr_q] <= spi_wdata;
    else if (host_we && !busy_q)
      mem_q[host_addr] <= host_wdata;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;
  assign host_rdata  = host_rdata_q;

endmodule
